word_collector: RTL and testbench
=================================

// Module: word_collector
// PURPOSE
//  Downstream stage of the byte-to-word shift pipeline. Watches the packed
//  32-bit shift-register output and its per-byte shift strobe, recognises
//  each 4-byte boundary, captures the completed word into a small FIFO and
//  presents it on a valid/ready interface to the next consumer.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >= 2
//  AW      2   log2(DEPTH); pointer width; fill_level is AW+1 bits
// PORTS
//  clock        in   1     single clock, all logic on posedge
//  clear        in   1     reset, synchronous, active-high
//  word_in      in   32    packed shift-register contents; newest byte in [7:0]
//  byte_strobe  in   1     word_in holds a newly shifted byte this cycle
//  resync       in   1     force byte alignment: next strobe counts as byte 1
//  out_data     out  32    FIFO head word
//  out_valid    out  1     out_data valid
//  out_ready    in   1     consumer accepts out_data when out_valid & out_ready
//  fill_level   out  AW+1  words currently held (0..DEPTH)
//  overflow     out  1     sticky: a completed word was dropped
//  drop_count   out  16    words dropped (only with WC_DROP_COUNT_EN)
// BEHAVIOUR
//  Clock is clock. Reset is clear, synchronous and active-high.
//  Reset (clear=1 at posedge): byte_cnt=0, FIFO emptied, out_valid=0,
//   out_data=0, fill_level=0, overflow=0, drop_count=0; overrides all inputs.
//  Byte counter byte_cnt[1:0]:
//   - strobe & !resync: byte_cnt+1 (wraps 3->0).
//   - strobe & byte_cnt==3: word complete; push = word_in sampled this cycle.
//   - resync & !strobe: byte_cnt<=0. resync & strobe: byte_cnt<=1, no push.
//  FIFO (show-ahead): pop = out_valid & out_ready.
//   - push when not full: write at wr_ptr. Push when full: accepted only if
//     pop in the same cycle; otherwise word dropped, overflow<=1 (sticky
//     until clear), drop_count+1 saturating at 16'hFFFF.
//   - push & pop same cycle: fill_level unchanged; order preserved.
//   - pop when empty impossible (out_valid=0).
//   - pointers wrap modulo DEPTH; fill_level via separate counter.
//  Latency: word completed in cycle N -> out_valid=1, out_data=word at N+1
//   if FIFO was empty. out_data/out_valid stable while out_valid & !out_ready.
//  Data is never altered; out_data equals word_in at the completing strobe.
// CONFIGURATION
//  WC_DROP_COUNT_EN defined: drop_count port and 16-bit saturating counter.
//  Not defined: drop_count port absent; overflow flag only; no other change.
// TESTING
//  1. clear 2 cycles, then 4 strobes with word_in 0x000000A1,0x0000A1B2,
//     0x00A1B2C3,0xA1B2C3D4, out_ready=1 -> one cycle after 4th strobe
//     out_valid=1, out_data=0xA1B2C3D4, fill_level=1; then 0.
//  2. out_ready=0, 16 strobes (4 words) DEPTH=4 -> fill_level=4, overflow=0;
//     4 more strobes -> word dropped, overflow=1, drop_count=1 (if EN).
//  3. FIFO full, 4th strobe in same cycle as out_ready=1 -> pop & push,
//     fill_level stays 4, overflow stays 0, order FIFO-correct.
//  4. 2 strobes then resync+strobe, then 3 strobes -> exactly one word
//     pushed on the 3rd later strobe (4th after resync).
//  5. clear asserted with fill_level=3, overflow=1 mid-stream -> next cycle
//     out_valid=0, fill_level=0, overflow=0, byte_cnt=0.
//  6. random strobe gaps and out_ready backpressure, 1000 words -> output
//     sequence equals scoreboard of completed words minus counted drops.

Source files
------------

// File: rtl/word_collector_if.sv
// Byte-stream input, word valid/ready output and status bundle for word_collector.
// master = producer/consumer environment, slave = word_collector; WC_DROP_COUNT_EN adds drop_count.
interface word_collector_if #(
    parameter int AW = 2
) ();
    logic [31:0] word_in;
    logic        byte_strobe;
    logic        resync;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [AW:0] fill_level;
    logic        overflow;
`ifdef WC_DROP_COUNT_EN
    logic [15:0] drop_count;

    modport master (
        output word_in, byte_strobe, resync, out_ready,
        input  out_data, out_valid, fill_level, overflow, drop_count
    );
    modport slave (
        input  word_in, byte_strobe, resync, out_ready,
        output out_data, out_valid, fill_level, overflow, drop_count
    );
`else
    modport master (
        output word_in, byte_strobe, resync, out_ready,
        input  out_data, out_valid, fill_level, overflow
    );
    modport slave (
        input  word_in, byte_strobe, resync, out_ready,
        output out_data, out_valid, fill_level, overflow
    );
`endif
endinterface

// File: rtl/word_collector.sv
// Captures every 4th strobed shift-register word into a show-ahead FIFO; 1-cycle latency to out_valid.
// Push into a full FIFO without a same-cycle pop drops the word (sticky overflow; WC_DROP_COUNT_EN adds drop_count).
module word_collector #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic            clock,
    input  logic            clear,
    word_collector_if.slave bus
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;

    logic word_done;
    logic pop;
    logic full;
    logic push_ok;
    logic drop;

    always_comb begin
        word_done = bus.byte_strobe && !bus.resync && (byte_cnt_q == 2'd3);
        pop       = (level_q != '0) && bus.out_ready;
        full      = (level_q == FULL_LVL);
        // A full FIFO still takes the word if the head leaves this same cycle.
        push_ok   = word_done && (!full || pop);
        drop      = word_done && full && !pop;

        byte_cnt_d = byte_cnt_q;
        if (bus.resync) begin
            byte_cnt_d = bus.byte_strobe ? 2'd1 : 2'd0;
        end else if (bus.byte_strobe) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
        end

        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        case ({push_ok, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase

        overflow_d = overflow_q || drop;
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            byte_cnt_q <= 2'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: entries are only visible while level_q covers them.
    always_ff @(posedge clock) begin
        if (!clear && push_ok) begin
            mem_q[wr_ptr_q] <= bus.word_in;
        end
    end

    assign bus.out_valid  = (level_q != '0);
    assign bus.out_data   = bus.out_valid ? mem_q[rd_ptr_q] : 32'd0;
    assign bus.fill_level = level_q;
    assign bus.overflow   = overflow_q;

`ifdef WC_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            drop_cnt_q <= 16'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.drop_count = drop_cnt_q;
`endif
endmodule

// File: tb/tb_word_collector.sv
// Directed and randomised bench for word_collector with a queue-based reference model.
module tb_word_collector;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic clock = 1'b0;
    logic clear = 1'b1;
    always #5 clock = ~clock;

    word_collector_if #(.AW(AW)) bus ();

    word_collector #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: bytes since alignment, queue of held words, drop tally.
    logic [31:0] mq[$];
    int          m_bytes = 0;
    bit          m_ovf   = 0;
    int          m_done  = 0;
    int          m_drops = 0;
    bit          m_pop;
    bit          chk_en  = 0;
    int          dut_pops = 0;

    always @(posedge clock) begin
        if (clear) begin
            mq.delete();
            m_bytes = 0;
            m_ovf   = 0;
            m_done  = 0;
            m_drops = 0;
        end else begin
            m_pop = (mq.size() > 0) && bus.out_ready;
            if (m_pop) void'(mq.pop_front());
            if (bus.resync) begin
                m_bytes = bus.byte_strobe ? 1 : 0;
            end else if (bus.byte_strobe) begin
                m_bytes = m_bytes + 1;
                if (m_bytes % 4 == 0) begin
                    m_done++;
                    if (mq.size() < DEPTH) begin
                        mq.push_back(bus.word_in);
                    end else begin
                        m_drops++;
                        m_ovf = 1;
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
            check("fill_level", 32'(bus.fill_level), 32'(mq.size()));
            check("overflow", 32'(bus.overflow), 32'(m_ovf));
            if (mq.size() > 0) check("out_data", bus.out_data, mq[0]);
`ifdef WC_DROP_COUNT_EN
            check("drop_count", 32'(bus.drop_count), (m_drops > 65535) ? 32'hFFFF : 32'(m_drops));
`endif
            if (clear) dut_pops = 0;
            else if (bus.out_valid && bus.out_ready) dut_pops++;
        end
    end

    logic [31:0] sr = 32'd0;
    logic [7:0]  nb = 8'd0;

    task automatic tick(input bit stb, input bit rs, input bit rdy, input bit clr, input logic [7:0] b);
        if (stb) sr = {sr[23:0], b};
        bus.byte_strobe = stb;
        bus.resync      = rs;
        bus.out_ready   = rdy;
        bus.word_in     = sr;
        clear           = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic sb(input bit rs, input bit rdy);
        tick(1'b1, rs, rdy, 1'b0, nb);
        nb = nb + 8'd1;
    endtask

    task automatic idle(input bit rdy);
        tick(1'b0, 1'b0, rdy, 1'b0, 8'd0);
    endtask

    initial begin
        bus.word_in     = 32'd0;
        bus.byte_strobe = 1'b0;
        bus.resync      = 1'b0;
        bus.out_ready   = 1'b0;

        // Test 1: reset state, single word latency
        tick(0, 0, 0, 1, 8'd0);
        chk_en = 1;
        tick(0, 0, 0, 1, 8'd0);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        check("rst_data", bus.out_data, 32'd0);
        check("rst_fill", 32'(bus.fill_level), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        tick(1, 0, 1, 0, 8'hA1);
        tick(1, 0, 1, 0, 8'hB2);
        tick(1, 0, 1, 0, 8'hC3);
        check("t1_fill3", 32'(bus.fill_level), 32'd0);
        tick(1, 0, 1, 0, 8'hD4);
        check("t1_valid", 32'(bus.out_valid), 32'd1);
        check("t1_data", bus.out_data, 32'hA1B2C3D4);
        check("t1_fill", 32'(bus.fill_level), 32'd1);
        idle(1);
        check("t1_valid_after", 32'(bus.out_valid), 32'd0);
        check("t1_fill_after", 32'(bus.fill_level), 32'd0);

        // Test 2: fill to DEPTH, then one dropped word
        nb = 8'h01;
        for (int i = 0; i < 16; i++) sb(0, 0);
        check("t2_fill_full", 32'(bus.fill_level), 32'd4);
        check("t2_ovf0", 32'(bus.overflow), 32'd0);
        check("t2_head", bus.out_data, 32'h01020304);
        for (int i = 0; i < 4; i++) sb(0, 0);
        check("t2_ovf1", 32'(bus.overflow), 32'd1);
        check("t2_fill_keep", 32'(bus.fill_level), 32'd4);
`ifdef WC_DROP_COUNT_EN
        check("t2_drops", 32'(bus.drop_count), 32'd1);
`endif

        // Test 3: push into full FIFO with simultaneous pop
        tick(0, 0, 0, 1, 8'd0);
        nb = 8'h10;
        for (int i = 0; i < 19; i++) sb(0, 0);
        sb(0, 1);
        check("t3_fill", 32'(bus.fill_level), 32'd4);
        check("t3_ovf", 32'(bus.overflow), 32'd0);
        check("t3_head", bus.out_data, 32'h14151617);
        for (int i = 0; i < 6; i++) idle(1);
        check("t3_drained", 32'(bus.fill_level), 32'd0);

        // Test 4: resync realigns byte counting
        tick(0, 0, 0, 1, 8'd0);
        nb = 8'h40;
        sb(0, 0);
        sb(0, 0);
        sb(1, 0);
        sb(0, 0);
        sb(0, 0);
        check("t4_nopush", 32'(bus.fill_level), 32'd0);
        sb(0, 0);
        check("t4_push", 32'(bus.fill_level), 32'd1);
        check("t4_word", bus.out_data, 32'h42434445);

        // Test 5: clear mid-stream with fill 3 and overflow set
        tick(0, 0, 0, 1, 8'd0);
        nb = 8'h60;
        for (int i = 0; i < 20; i++) sb(0, 0);
        idle(1);
        check("t5_pre_fill", 32'(bus.fill_level), 32'd3);
        check("t5_pre_ovf", 32'(bus.overflow), 32'd1);
        sb(0, 0);
        sb(0, 0);
        tick(1, 0, 0, 1, 8'h77);
        check("t5_valid", 32'(bus.out_valid), 32'd0);
        check("t5_fill", 32'(bus.fill_level), 32'd0);
        check("t5_ovf", 32'(bus.overflow), 32'd0);
`ifdef WC_DROP_COUNT_EN
        check("t5_drops", 32'(bus.drop_count), 32'd0);
`endif
        for (int i = 0; i < 3; i++) sb(0, 0);
        check("t5_cnt3", 32'(bus.fill_level), 32'd0);
        sb(0, 0);
        check("t5_cnt4", 32'(bus.fill_level), 32'd1);

        // Test 6: random gaps and backpressure over 1000 words
        tick(0, 0, 0, 1, 8'd0);
        for (int s = 0; s < 4000; ) begin
            logic [7:0] rb;
            bit         stb;
            bit         rdy;
            rb  = 8'($urandom);
            stb = ($urandom_range(0, 9) < 6);
            rdy = ($urandom_range(0, 9) < 5);
            tick(stb, 1'b0, rdy, 1'b0, rb);
            if (stb) s++;
        end
        for (int i = 0; i < DEPTH + 4; i++) idle(1);
        check("t6_fill_end", 32'(bus.fill_level), 32'd0);
        check("t6_pops", 32'(dut_pops), 32'(m_done - m_drops));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
